// File: rtl/sdram_cmd_ctrl.sv
// sdram_cmd_ctrl: single-outstanding-request SDRAM command sequencer.
// Each host request runs ACTIVATE -> READ/WRITE -> NOP wait -> completion pulse.
// All SDRAM pins and host-facing outputs come straight from flops. The flops are
// loaded from the next state, so the pins always show the command of the current state.
// Optional feature: define SDRAM_ROW_HIT_EN to remember the last activated {bank,row}.
// A request that matches it skips ACTIVATE.

module sdram_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_BITS   = 11,
  parameter int unsigned COL_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_bank,
  input  logic [ROW_BITS-1:0]   req_row,
  input  logic [COL_BITS-1:0]   req_col,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  cs_n,
  output logic                  ras_n,
  output logic                  cas_n,
  output logic                  we_n,
  output logic [ROW_BITS-1:0]   sdram_addr,
  output logic [1:0]            bank_select,
  output logic [DATA_WIDTH-1:0] dq_in,
  input  logic [DATA_WIDTH-1:0] dq_out
);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdDeselect = 4'b1111;
  localparam logic [3:0] CmdNop      = 4'b0111;
  localparam logic [3:0] CmdActivate = 4'b0011;
  localparam logic [3:0] CmdRead     = 4'b0101;
  localparam logic [3:0] CmdWrite    = 4'b0100;

  typedef enum logic [2:0] {StIdle, StAct, StCmd, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  lat_we_q, lat_we_d;
  logic [1:0]            lat_bank_q, lat_bank_d;
  logic [ROW_BITS-1:0]   lat_row_q, lat_row_d;
  logic [COL_BITS-1:0]   lat_col_q, lat_col_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;

  logic [3:0]            cmd_q, cmd_d;
  logic [ROW_BITS-1:0]   addr_q, addr_d;
  logic [1:0]            bank_q, bank_d;
  logic [DATA_WIDTH-1:0] dq_in_q, dq_in_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;

  logic                  accept;

  assign accept = (state_q == StIdle) && req_valid && ready_q;

`ifdef SDRAM_ROW_HIT_EN
  logic                rec_valid_q, rec_valid_d;
  logic [1:0]          rec_bank_q, rec_bank_d;
  logic [ROW_BITS-1:0] rec_row_q, rec_row_d;
  logic                row_hit;

  assign row_hit = rec_valid_q && (rec_bank_q == req_bank) && (rec_row_q == req_row);

  // Open-row record; only cleared by reset, refreshed on every ACTIVATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid_q <= 1'b0;
      rec_bank_q  <= '0;
      rec_row_q   <= '0;
    end else begin
      rec_valid_q <= rec_valid_d;
      rec_bank_q  <= rec_bank_d;
      rec_row_q   <= rec_row_d;
    end
  end
`endif

  // State register plus latched request and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_bank_q  <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_bank_q  <= lat_bank_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Next-state logic: request capture, sequencing and NOP wait count
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_bank_d  = lat_bank_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    lat_wdata_d = lat_wdata_q;
`ifdef SDRAM_ROW_HIT_EN
    rec_valid_d = rec_valid_q;
    rec_bank_d  = rec_bank_q;
    rec_row_d   = rec_row_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lat_we_d    = req_we;
          lat_bank_d  = req_bank;
          lat_row_d   = req_row;
          lat_col_d   = req_col;
          lat_wdata_d = req_wdata;
`ifdef SDRAM_ROW_HIT_EN
          if (row_hit) begin
            state_d = StCmd;
          end else begin
            state_d     = StAct;
            rec_valid_d = 1'b1;
            rec_bank_d  = req_bank;
            rec_row_d   = req_row;
          end
`else
          state_d = StAct;
`endif
        end
      end
      StAct: state_d = StCmd;
      StCmd: begin
        // Counter value is the number of extra WAIT cycles after the first one
        cnt_d   = lat_we_q ? 2'd2 : 2'd1;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next values, decoded from the state being entered
  always_comb begin
    cmd_d       = CmdDeselect;
    addr_d      = addr_q;
    bank_d      = bank_q;
    dq_in_d     = dq_in_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    unique case (state_d)
      StIdle: begin
        ready_d = 1'b1;
      end
      StAct: begin
        cmd_d  = CmdActivate;
        addr_d = lat_row_d;
        bank_d = lat_bank_d;
      end
      StCmd: begin
        cmd_d   = lat_we_d ? CmdWrite : CmdRead;
        addr_d  = ROW_BITS'(lat_col_d);
        bank_d  = lat_bank_d;
        dq_in_d = lat_wdata_d;
      end
      StWait: begin
        cmd_d = CmdNop;
      end
      StDone: begin
        rsp_valid_d = 1'b1;
        // Read data is captured on the edge that leaves the last WAIT cycle
        if (!lat_we_q) begin
          rdata_d = dq_out;
        end
      end
      default: cmd_d = CmdDeselect;
    endcase
  end

  // Output registers: no combinational path from host inputs to any pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= CmdDeselect;
      addr_q      <= '0;
      bank_q      <= '0;
      dq_in_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      bank_q      <= bank_d;
      dq_in_q     <= dq_in_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign sdram_addr  = addr_q;
  assign bank_select = bank_q;
  assign dq_in       = dq_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign req_ready   = ready_q;

endmodule

// File: doc/sdram_cmd_ctrl.md
SDRAM_CMD_CTRL -- requirements
Module: sdram_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the data bus.
REQ-002 SHALL have parameter ROW_BITS, default 11, row address width; also the sdram_addr width.
REQ-003 SHALL have parameter COL_BITS, default 8, column address width; COL_BITS <= ROW_BITS.
REQ-004 SHALL have ports:
- clk  input  1  sole clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  host request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_bank  input  2  target bank.
- req_row  input  ROW_BITS  target row.
- req_col  input  COL_BITS  target column.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid after a read.
- cs_n, ras_n, cas_n, we_n  output  1 each  SDRAM command pins, active-low.
- sdram_addr  output  ROW_BITS  row on ACTIVATE; zero-extended column on READ/WRITE.
- bank_select  output  2  bank on ACTIVATE/READ/WRITE.
- dq_in  output  DATA_WIDTH  write data to memory.
- dq_out  input  DATA_WIDTH  read data from memory.

Function
REQ-005 SHALL encode commands {cs_n,ras_n,cas_n,we_n}: DESELECT 1111, NOP 0111, ACTIVATE 0011, READ 0101, WRITE 0100.
REQ-006 SHALL drive all command pins from registers, with no combinational path from host inputs to SDRAM pins.
REQ-007 SHALL implement FSM states IDLE, ACT, CMD, WAIT, DONE, advancing one state per clock except WAIT.
REQ-008 IDLE: req_ready=1, DESELECT driven; on req_valid&&req_ready, latch we/bank/row/col/wdata and go to ACT.
REQ-009 ACT: drive ACTIVATE with sdram_addr=row, bank_select=bank; go to CMD.
REQ-010 CMD: drive READ or WRITE with sdram_addr={zeros,col}, bank_select=bank, dq_in=wdata; load wait counter; go to WAIT.
REQ-011 WAIT: drive NOP (cs_n=0); stay for 2 cycles after READ or 3 cycles after WRITE, then go to DONE.
REQ-012 DONE: pulse rsp_valid for one cycle; drive DESELECT; return to IDLE.
- After a read, rsp_rdata = dq_out sampled at the edge ending the last WAIT cycle.
- After a write, rsp_rdata holds its previous value.
REQ-013 SHALL hold req_ready=0 in every state except IDLE, and SHALL ignore req_valid while req_ready=0.
REQ-014 Latency from the accepting edge to rsp_valid high: read 5 cycles, write 6 cycles (no row hit).
REQ-015 SHALL hold dq_in at the latched wdata from CMD through DONE.
REQ-016 Wait counter SHALL be 2 bits, load and decrement only, never wrap.

Reset
REQ-017 While rst_n=0, all state SHALL clear immediately:
- FSM in IDLE.
- cs_n=ras_n=cas_n=we_n=1.
- sdram_addr, bank_select, dq_in, rsp_rdata = 0.
- rsp_valid=0, req_ready=0.
- Open-row record invalid.
REQ-018 req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-019 Reset mid-operation SHALL abort the request with no rsp_valid; a write aborted before its third NOP is not committed.

Configuration
REQ-020 Macro SDRAM_ROW_HIT_EN: when defined, track the last activated {bank,row} plus a valid bit.
- On a request matching a valid record, go IDLE->CMD directly, skipping ACT; latency is 1 cycle shorter.
- On a mismatch, perform ACT and update the record.
- When the macro is undefined, every request performs ACT, and no record logic exists.

Verification
REQ-021 Write bank 1, row 0x005, col 0x03, data 0xBEEF -> pins ACT, WRITE, NOP x3; rsp_valid at cycle 6 after accept.
REQ-022 Read back the same address -> ACT, READ, NOP x2; rsp_valid at cycle 5 with rsp_rdata=0xBEEF.
REQ-023 Write 0x1111 to bank 0 and 0x2222 to bank 3 at row 0x7FF, col 0xFF -> reads return 0x1111 and 0x2222 respectively.
REQ-024 Hold req_valid high back-to-back -> exactly one acceptance per IDLE cycle; req_ready=0 elsewhere; no lost or duplicated request.
REQ-025 Assert rst_n=0 during the WRITE WAIT state -> pins 1111 immediately; no rsp_valid; a later read of that address does not return the aborted data.
REQ-026 With SDRAM_ROW_HIT_EN, a second read on the same bank/row -> no ACTIVATE, rsp_valid at cycle 4; a different row -> ACTIVATE issued.
